// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// pc_sel and forwarding-select values must match the datapath muxes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MWAIT,
        IRQ
    } state_e;

    localparam logic [1:0] PCSEL_PC4    = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_JUMP   = 2'd2;
    localparam logic [1:0] PCSEL_IRQ    = 2'd3;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEMWB   = 2'd1;
    localparam logic [1:0] FWD_EXMEM   = 2'd2;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding selects for the EX stage; purely combinational.
// The younger EX/MEM result wins over MEM/WB, and register 0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       mem_regwrite,
    input  logic [4:0] mem_regdest,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_regdest,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic mem_fwd_ok;
    logic wb_fwd_ok;

    assign mem_fwd_ok = mem_regwrite && (mem_regdest != 5'd0);
    assign wb_fwd_ok  = wb_regwrite && (wb_regdest != 5'd0);

    always_comb begin
        fwd_a = FWD_REGFILE;
        if (mem_fwd_ok && (mem_regdest == ex_rs)) begin
            fwd_a = FWD_EXMEM;
        end else if (wb_fwd_ok && (wb_regdest == ex_rs)) begin
            fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b = FWD_REGFILE;
        if (mem_fwd_ok && (mem_regdest == ex_rt)) begin
            fwd_b = FWD_EXMEM;
        end else if (wb_fwd_ok && (wb_regdest == ex_rt)) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes, PC mux select, data-memory freeze with timeout,
// and single-cycle interrupt entry with EPC capture.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_regdest,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_regdest,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_regdest,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        irq,
    input  logic        eret,
    input  logic [31:0] id_pc,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  pc_sel,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] epc,
    output logic        irq_active,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]       epc_q, epc_d;
    logic              irq_active_q, irq_active_d;
    logic              bus_err_q, bus_err_d;
    logic              load_use;

    assign load_use = ex_memread && (ex_regdest != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_regdest)) ||
                       (id_use_rt && (id_rt == ex_regdest)));

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pc_sel       = PCSEL_PC4;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        epc_d        = epc_q;
        irq_active_d = irq_active_q;
        bus_err_d    = 1'b0;

        unique case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_req && !mem_ready) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                    state_d    = MWAIT;
                    wait_cnt_d = CNT_W'(1);
                end else if (ex_branch_taken) begin
                    // The ID instruction is squashed, so any load-use on it is moot.
                    pc_sel     = PCSEL_BRANCH;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (id_jump || eret) begin
                    // eret reuses the jump path; the datapath supplies epc as target.
                    pc_sel     = PCSEL_JUMP;
                    ifid_flush = 1'b1;
                    if (eret) begin
                        irq_active_d = 1'b0;
                    end
                end else if (irq && !irq_active_q) begin
                    pc_sel     = PCSEL_IRQ;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    epc_d      = id_pc;
                    state_d    = IRQ;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MWAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TimeoutCnt) begin
                    // Abandon the access and let MEM/WB advance past it.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    exmem_en   = 1'b0;
                    bus_err_d  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            IRQ: begin
                irq_active_d = 1'b1;
                state_d      = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            epc_q        <= '0;
            irq_active_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            epc_q        <= epc_d;
            irq_active_q <= irq_active_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign epc        = epc_q;
    assign irq_active = irq_active_q;
    assign bus_err    = bus_err_q;

    fwd_unit u_fwd_unit (
        .mem_regwrite (mem_regwrite),
        .mem_regdest  (mem_regdest),
        .wb_regwrite  (wb_regwrite),
        .wb_regdest   (wb_regdest),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_regdest, mem_regdest, wb_regdest, ex_rs, ex_rt;
    logic        id_use_rs, id_use_rt, ex_memread, mem_regwrite, wb_regwrite;
    logic        ex_branch_taken, id_jump, mem_req, mem_ready, irq, eret;
    logic [31:0] id_pc;
    logic        pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [1:0]  pc_sel, fwd_a, fwd_b;
    logic [31:0] epc;
    logic        irq_active, bus_err;

    int checks = 0;
    int errors = 0;

    // Model state: frozen on memory, cycles spent frozen, vector-fetch cycle pending.
    bit          m_frozen, m_vec, m_act, m_berr;
    int          m_fcnt;
    logic [31:0] m_epc;
    bit          n_frozen, n_vec, n_act, n_berr;
    int          n_fcnt;
    logic [31:0] n_epc;
    bit          e_pc, e_ifid, e_exmem, e_memwb, e_iff, e_idf;
    int          e_sel, e_fa, e_fb;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_memread(ex_memread), .ex_regdest(ex_regdest),
        .mem_regwrite(mem_regwrite), .mem_regdest(mem_regdest), .wb_regwrite(wb_regwrite),
        .wb_regdest(wb_regdest), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_req(mem_req),
        .mem_ready(mem_ready), .irq(irq), .eret(eret), .id_pc(id_pc), .pc_en(pc_en),
        .ifid_en(ifid_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_sel(pc_sel), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .epc(epc), .irq_active(irq_active), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd(input logic [4:0] src);
        if (mem_regwrite && mem_regdest != 0 && mem_regdest == src) return 2;
        if (wb_regwrite && wb_regdest != 0 && wb_regdest == src) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_frozen = 0; m_vec = 0; m_act = 0; m_berr = 0; m_fcnt = 0; m_epc = 0;
    endtask

    task automatic model_comb();
        bit lu;
        lu = ex_memread && ex_regdest != 0 &&
             ((id_use_rs && id_rs == ex_regdest) || (id_use_rt && id_rt == ex_regdest));
        {e_pc, e_ifid, e_exmem, e_memwb} = 4'b1111;
        e_iff = 0; e_idf = 0; e_sel = 0;
        e_fa = fwd(ex_rs); e_fb = fwd(ex_rt);
        n_frozen = m_frozen; n_fcnt = 0; n_vec = 0; n_epc = m_epc; n_act = m_act; n_berr = 0;
        if (m_frozen) begin
            if (mem_ready) n_frozen = 0;
            else if (m_fcnt == TIMEOUT) begin
                {e_pc, e_ifid, e_exmem} = 3'b000;
                n_berr = 1; n_frozen = 0;
            end else begin
                {e_pc, e_ifid, e_exmem, e_memwb} = 4'b0000;
                n_fcnt = m_fcnt + 1;
            end
        end else if (m_vec) n_act = 1;
        else if (mem_req && !mem_ready) begin
            {e_pc, e_ifid, e_exmem, e_memwb} = 4'b0000;
            n_frozen = 1; n_fcnt = 1;
        end else if (ex_branch_taken) begin
            e_sel = 1; e_iff = 1; e_idf = 1;
        end else if (id_jump || eret) begin
            e_sel = 2; e_iff = 1;
            if (eret) n_act = 0;
        end else if (irq && !m_act) begin
            e_sel = 3; e_iff = 1; e_idf = 1; n_epc = id_pc; n_vec = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_idf = 1;
        end
    endtask

    task automatic check_regs();
        check("epc", epc, m_epc);
        check("irq_active", {31'b0, irq_active}, {31'b0, m_act});
        check("bus_err", {31'b0, bus_err}, {31'b0, m_berr});
    endtask

    // Compare combinational outputs mid-cycle, clock, then compare registered outputs.
    task automatic step();
        #2;
        model_comb();
        check("enables", {28'b0, pc_en, ifid_en, exmem_en, memwb_en},
              {28'b0, e_pc, e_ifid, e_exmem, e_memwb});
        check("flushes", {30'b0, ifid_flush, idex_flush}, {30'b0, e_iff, e_idf});
        check("pc_sel", {30'b0, pc_sel}, 32'(e_sel));
        check("fwd_a", {30'b0, fwd_a}, 32'(e_fa));
        check("fwd_b", {30'b0, fwd_b}, 32'(e_fb));
        @(posedge clk);
        m_frozen = n_frozen; m_fcnt = n_fcnt; m_vec = n_vec;
        m_epc = n_epc; m_act = n_act; m_berr = n_berr;
        #1;
        check_regs();
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_regdest, mem_regdest, wb_regdest, ex_rs, ex_rt} = '0;
        {id_use_rs, id_use_rt, ex_memread, mem_regwrite, wb_regwrite} = '0;
        {ex_branch_taken, id_jump, mem_req, mem_ready, irq, eret} = '0;
        id_pc = '0;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        clear_inputs();
        reset = 1'b0;
        #3;
        async_reset();
        #1;
        check("reset pc_en", {31'b0, pc_en}, 32'd1);
        check("reset pc_sel", {30'b0, pc_sel}, 32'd0);
        step();

        // Load-use on rs stalls exactly one cycle.
        ex_memread = 1; ex_regdest = 8; id_rs = 8; id_use_rs = 1;
        #1;
        check("lu stall", {29'b0, pc_en, ifid_en, idex_flush}, 32'b001);
        step();
        ex_memread = 0;
        #1;
        check("lu release", {29'b0, pc_en, ifid_en, idex_flush}, 32'b110);
        step();
        ex_memread = 1; ex_regdest = 0; id_rs = 0;
        #1;
        check("lu r0", {31'b0, pc_en}, 32'd1);
        step();
        ex_regdest = 8; id_use_rs = 0; id_use_rt = 0; id_rt = 8;
        #1;
        check("lu rt unused", {31'b0, pc_en}, 32'd1);
        step();
        clear_inputs();

        // Memory wait of three cycles, resuming on the fourth.
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mwait frozen", {30'b0, pc_en, memwb_en}, 32'b00);
            step();
        end
        mem_ready = 1;
        #1;
        check("mwait resume", {28'b0, pc_en, ifid_en, exmem_en, memwb_en}, 32'hf);
        step();
        check("mwait no bus_err", {31'b0, bus_err}, 32'd0);
        mem_ready = 0;

        // Memory never ready: bus_err after one RUN cycle plus TIMEOUT frozen cycles.
        n = 0;
        while (bus_err !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("timeout cycles", 32'(n), 32'(TIMEOUT + 1));
        mem_req = 0;
        #1;
        check("timeout back in run", {31'b0, pc_en}, 32'd1);
        step();
        check("bus_err pulse", {31'b0, bus_err}, 32'd0);

        // Branch overrides a simultaneous load-use.
        ex_branch_taken = 1; ex_memread = 1; ex_regdest = 8; id_rs = 8; id_use_rs = 1;
        #1;
        check("branch lu", {27'b0, pc_sel, ifid_flush, idex_flush, pc_en}, 32'b01111);
        step();
        clear_inputs();

        // Interrupt entry, masking, return.
        id_pc = 32'h0040_0020; irq = 1;
        #1;
        check("irq sel", {30'b0, pc_sel}, 32'd3);
        step();
        check("irq epc", epc, 32'h0040_0020);
        step();
        check("irq active", {31'b0, irq_active}, 32'd1);
        #1;
        check("irq masked", {30'b0, pc_sel}, 32'd0);
        step();
        irq = 0; eret = 1;
        #1;
        check("eret sel", {29'b0, pc_sel, ifid_flush}, 32'b101);
        step();
        check("eret clears", {31'b0, irq_active}, 32'd0);
        eret = 0; irq = 1;
        step();
        async_reset();
        #1;
        check("reset mid irq", {30'b0, pc_sel}, 32'd3);
        step();
        clear_inputs();
        step();

        // Forwarding priority.
        mem_regwrite = 1; wb_regwrite = 1; mem_regdest = 5; wb_regdest = 5; ex_rs = 5;
        #1;
        check("fwd exmem", {30'b0, fwd_a}, 32'd2);
        step();
        mem_regwrite = 0;
        #1;
        check("fwd memwb", {30'b0, fwd_a}, 32'd1);
        step();
        clear_inputs();

        // Reset while frozen on memory.
        mem_req = 1;
        step();
        step();
        async_reset();
        mem_req = 0;
        #1;
        check("reset mid mwait", {31'b0, pc_en}, 32'd1);
        step();

        for (int i = 0; i < 600; i++) begin
            id_rs = 5'($urandom_range(0, 3));       id_rt = 5'($urandom_range(0, 3));
            ex_regdest = 5'($urandom_range(0, 3));  mem_regdest = 5'($urandom_range(0, 3));
            wb_regdest = 5'($urandom_range(0, 3));  ex_rs = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            {id_use_rs, id_use_rt, ex_memread, mem_regwrite, wb_regwrite} = 5'($urandom);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_jump = ($urandom_range(0, 7) == 0);
            eret = ($urandom_range(0, 7) == 0);
            irq = ($urandom_range(0, 5) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = $urandom_range(0, 1) == 1;
            id_pc = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
